// File: rtl/sample_player.sv
// Playback engine: streams signed samples out of an audio RAM read port, one per
// audio strobe, with a one-sample prefetch to hide the RAM read latency.
module sample_player #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         play_in,
  input  logic                         stop_in,
  input  logic                         loop_in,
  input  logic [ADDR_WIDTH-1:0]        length_in,
  input  logic                         audio_valid_in,
  output logic [ADDR_WIDTH-1:0]        ram_addr_out,
  input  logic signed [DATA_WIDTH-1:0] ram_data_in,
  output logic signed [DATA_WIDTH-1:0] audio_out,
  output logic                         audio_valid_out,
  output logic                         busy_out,
  output logic                         done_out,
  output logic                         underrun_out,
  output logic [1:0]                   state_dbg_out
);

  // Handshake: audio_valid_in is a bare strobe (no ready); audio_valid_out is a
  // one-cycle pulse qualifying the registered audio_out, with no back-pressure.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREFETCH = 2'd1,
    S_READY    = 2'd2
  } state_t;

  localparam int CW = $clog2(READ_LATENCY + 2) + 1;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]         len_q, len_d;
  logic                          loop_q, loop_d;
  logic signed [DATA_WIDTH-1:0]  buf_q, buf_d;
  logic signed [DATA_WIDTH-1:0]  audio_q, audio_d;
  logic                          valid_q, valid_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          underrun_q, underrun_d;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    len_d      = len_q;
    loop_d     = loop_q;
    buf_d      = buf_q;
    audio_d    = audio_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    underrun_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (play_in && !stop_in && (length_in != '0)) begin
          len_d   = length_in;
          loop_d  = loop_in;
          addr_d  = '0;
          wait_d  = '0;
          state_d = S_PREFETCH;
        end
      end
      S_PREFETCH: begin
        if (stop_in) begin
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + CW'(1);
          if (audio_valid_in) underrun_d = 1'b1;
          if (wait_q == CW'(READ_LATENCY)) begin
            buf_d   = ram_data_in;
            state_d = S_READY;
          end
        end
      end
      S_READY: begin
        if (stop_in) begin
          state_d = S_IDLE;
        end else if (audio_valid_in) begin
          audio_d = buf_q;
          valid_d = 1'b1;
          // After an address step the counter starts at all-ones, giving one
          // extra settling cycle before the read latency is counted.
          if (addr_q != len_q - ADDR_WIDTH'(1)) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            wait_d  = '1;
            state_d = S_PREFETCH;
          end else if (loop_q) begin
            addr_d  = '0;
            wait_d  = '1;
            state_d = S_PREFETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      buf_q      <= '0;
      audio_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      buf_q      <= buf_d;
      audio_q    <= audio_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign ram_addr_out    = addr_q;
  assign audio_out       = audio_q;
  assign audio_valid_out = valid_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign underrun_out    = underrun_q;
  assign state_dbg_out   = state_q;

endmodule

// File: tb/tb_sample_player.sv
// Directed bench for sample_player: RAM model with two-cycle read latency,
// hand-computed expectations checked with immediate assertions.
module tb_sample_player;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               play_in, stop_in, loop_in, audio_valid_in;
  logic [15:0]        length_in;
  logic [15:0]        ram_addr_out;
  logic signed [7:0]  ram_data_in;
  logic signed [7:0]  audio_out;
  logic               audio_valid_out, busy_out, done_out, underrun_out;
  logic [1:0]         state_dbg_out;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic signed [7:0] mem [0:15];
  logic signed [7:0] rd_p1, rd_p2;
  logic signed [7:0] exp_seq [0:3];

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    rd_p1 <= mem[ram_addr_out[3:0]];
    rd_p2 <= rd_p1;
  end
  assign ram_data_in = rd_p2;

  sample_player dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .play_in         (play_in),
    .stop_in         (stop_in),
    .loop_in         (loop_in),
    .length_in       (length_in),
    .audio_valid_in  (audio_valid_in),
    .ram_addr_out    (ram_addr_out),
    .ram_data_in     (ram_data_in),
    .audio_out       (audio_out),
    .audio_valid_out (audio_valid_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .underrun_out    (underrun_out),
    .state_dbg_out   (state_dbg_out)
  );

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
    cyc++;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic strobe_at(input int n);
    wait_until(n);
    audio_valid_in = 1'b1;
    tick();
    audio_valid_in = 1'b0;
  endtask

  task automatic start_play(input logic [15:0] len, input logic lp);
    play_in   = 1'b1;
    length_in = len;
    loop_in   = lp;
    cyc       = 0;
    tick();
    play_in   = 1'b0;
    loop_in   = 1'b0;
  endtask

  initial begin
    mem[0] = 8'sd5;  mem[1] = -8'sd3; mem[2] = 8'sd127; mem[3] = -8'sd128;
    for (int i = 4; i < 16; i++) mem[i] = 8'sd0;
    exp_seq[0] = 8'sd5; exp_seq[1] = -8'sd3; exp_seq[2] = 8'sd127; exp_seq[3] = -8'sd128;
    rst_in = 1'b0; play_in = 1'b0; stop_in = 1'b0; loop_in = 1'b0;
    audio_valid_in = 1'b0; length_in = 16'd0;
    @(negedge clk_in);
    tick();
    tick();
    check("rst_addr", ram_addr_out, 0);
    check("rst_audio", audio_out, 0);
    check("rst_valid", audio_valid_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_underrun", underrun_out, 0);
    rst_in = 1'b1;
    tick();

    // One-shot with latency probes and an ignored play while busy
    start_play(16'd4, 1'b0);
    check("os_busy_c1", busy_out, 1);
    check("os_addr_c1", ram_addr_out, 0);
    check("os_state_c1", state_dbg_out, 1);
    wait_until(3);
    check("os_state_c3", state_dbg_out, 1);
    wait_until(4);
    check("os_state_c4", state_dbg_out, 2);
    strobe_at(4);
    check("os_valid_s0", audio_valid_out, 1);
    check("os_audio_s0", audio_out, 5);
    check("os_addr_s0", ram_addr_out, 1);
    check("os_done_s0", done_out, 0);
    wait_until(6);
    play_in = 1'b1; length_in = 16'd1; loop_in = 1'b1;
    tick();
    play_in = 1'b0; loop_in = 1'b0; length_in = 16'd4;
    check("busy_play_busy", busy_out, 1);
    check("busy_play_addr", ram_addr_out, 1);
    strobe_at(9);
    check("os_valid_s1", audio_valid_out, 1);
    check("os_audio_s1", audio_out, -3);
    check("os_addr_s1", ram_addr_out, 2);
    check("os_underrun_5apart", underrun_out, 0);
    strobe_at(13);
    check("os_underrun_4apart", underrun_out, 1);
    check("os_valid_4apart", audio_valid_out, 0);
    check("os_audio_hold", audio_out, -3);
    check("os_state_c14", state_dbg_out, 2);
    strobe_at(14);
    check("os_valid_s2", audio_valid_out, 1);
    check("os_audio_s2", audio_out, 127);
    check("os_addr_s2", ram_addr_out, 3);
    strobe_at(25);
    check("os_valid_s3", audio_valid_out, 1);
    check("os_audio_s3", audio_out, -128);
    check("os_done_s3", done_out, 1);
    check("os_busy_s3", busy_out, 0);
    check("os_state_s3", state_dbg_out, 0);
    tick();
    check("os_done_after", done_out, 0);
    check("os_valid_after", audio_valid_out, 0);
    check("os_audio_after", audio_out, -128);
    strobe_at(28);
    check("idle_strobe_valid", audio_valid_out, 0);
    check("idle_strobe_busy", busy_out, 0);
    check("idle_strobe_underrun", underrun_out, 0);

    // Underrun during the initial prefetch, then stop with a strobe
    start_play(16'd4, 1'b0);
    strobe_at(2);
    check("ur_underrun", underrun_out, 1);
    check("ur_valid", audio_valid_out, 0);
    check("ur_audio_hold", audio_out, -128);
    tick();
    check("ur_underrun_clear", underrun_out, 0);
    strobe_at(10);
    check("ur_valid_s0", audio_valid_out, 1);
    check("ur_audio_s0", audio_out, 5);
    wait_until(15);
    check("st_state_c15", state_dbg_out, 2);
    stop_in = 1'b1; audio_valid_in = 1'b1;
    tick();
    stop_in = 1'b0; audio_valid_in = 1'b0;
    check("st_valid", audio_valid_out, 0);
    check("st_done", done_out, 0);
    check("st_busy", busy_out, 0);
    check("st_state", state_dbg_out, 0);
    check("st_audio_hold", audio_out, 5);

    // Looped playback, ten strobes
    start_play(16'd4, 1'b1);
    for (int k = 0; k < 10; k++) begin
      strobe_at(20 * (k + 1));
      check("lp_valid", audio_valid_out, 1);
      check("lp_audio", audio_out, exp_seq[k % 4]);
      check("lp_done", done_out, 0);
      check("lp_addr", ram_addr_out, (k + 1) % 4);
      check("lp_busy", busy_out, 1);
    end
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0;
    check("lp_stop_busy", busy_out, 0);

    // Ignored requests
    play_in = 1'b1; length_in = 16'd0;
    tick();
    play_in = 1'b0;
    check("len0_busy", busy_out, 0);
    check("len0_state", state_dbg_out, 0);
    play_in = 1'b1; stop_in = 1'b1; length_in = 16'd4;
    tick();
    play_in = 1'b0; stop_in = 1'b0;
    check("playstop_busy", busy_out, 0);
    tick();
    check("playstop_state", state_dbg_out, 0);

    // Asynchronous reset in the middle of a prefetch
    start_play(16'd4, 1'b0);
    tick();
    check("pre_rst_busy", busy_out, 1);
    rst_in = 1'b0;
    #1;
    check("arst_busy", busy_out, 0);
    check("arst_audio", audio_out, 0);
    check("arst_addr", ram_addr_out, 0);
    check("arst_state", state_dbg_out, 0);
    check("arst_done", done_out, 0);
    check("arst_valid", audio_valid_out, 0);
    tick();
    rst_in = 1'b1;
    tick();
    check("post_rst_busy", busy_out, 0);
    check("post_rst_done", done_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sample_player.md
# sample_player

Playback engine that reads back a buffer of signed audio samples previously written into a true-dual-port audio RAM by the recording path, and streams them out one sample per audio strobe. It drives the RAM read port directly, hides the RAM's read latency with a one-sample prefetch, and supports one-shot or looped playback, stop, and underrun reporting. Output feeds the downstream audio/PWM path at the same sample rate as the recorder's input strobe.

## Interface
- ADDR_WIDTH, 16, RAM address width; also the width of the sample count.
- DATA_WIDTH, 8, sample width (signed two's complement).
- READ_LATENCY, 2, cycles from ram_addr_out change to valid ram_data_in.

- clk_in  input  1  system clock; all logic on the rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- play_in  input  1  single-cycle start request; honoured only in IDLE.
- stop_in  input  1  single-cycle abort request; honoured in any state.
- loop_in  input  1  latched with play_in; 1 = restart at address 0 after the last sample.
- length_in  input  ADDR_WIDTH  number of valid samples in the buffer; latched with play_in.
- audio_valid_in  input  1  one-cycle sample-rate strobe.
- ram_addr_out  output  ADDR_WIDTH  RAM read address (registered).
- ram_data_in  input  signed DATA_WIDTH  RAM read data.
- audio_out  output  signed DATA_WIDTH  current output sample (registered).
- audio_valid_out  output  1  one-cycle pulse: new audio_out value.
- busy_out  output  1  high in every state except IDLE.
- done_out  output  1  one-cycle pulse on the final sample of a one-shot playback.
- underrun_out  output  1  one-cycle pulse: strobe arrived before a sample was ready.

## Operation
- States: IDLE, PREFETCH, READY.
- IDLE: play_in=1 with length_in!=0 and stop_in=0 -> latch length and loop; ram_addr_out<=0; wait counter<=0; go PREFETCH. play_in with length_in==0 is ignored (no outputs change).
- PREFETCH: wait counter increments each cycle; after READ_LATENCY+1 cycles in the state, capture ram_data_in into sample buffer; go READY.
- READY: on audio_valid_in: audio_out<=buffer, audio_valid_out<=1.
  - If ram_addr_out != length-1: ram_addr_out<=ram_addr_out+1; go PREFETCH.
  - Else if loop: ram_addr_out<=0; go PREFETCH.
  - Else: done_out<=1 (same cycle as the final audio_valid_out); go IDLE.
- audio_valid_in while in PREFETCH: underrun_out pulses; no audio_valid_out; audio_out holds; prefetch continues unaffected.
- audio_valid_in in IDLE: ignored.
- stop_in in PREFETCH or READY: go IDLE next cycle; no done_out; no audio_valid_out even if a strobe coincides. stop_in and play_in together in IDLE: stop wins, stay IDLE.
- play_in while busy: ignored; length_in and loop_in changes while busy: ignored.
- audio_out holds its value through IDLE after done/stop (last sample); cleared only by reset.
- Address arithmetic: unsigned ADDR_WIDTH; maximum length is 2^ADDR_WIDTH-1; no wrap beyond length-1.

## Timing
- Reset (asynchronous assertion, synchronous release): state IDLE, ram_addr_out=0, audio_out=0, audio_valid_out=0, busy_out=0, done_out=0, underrun_out=0, sample buffer=0.
- Reset mid-playback: immediate return to IDLE with all outputs at reset values; no done_out.
- play_in at cycle 0 -> busy_out=1 and ram_addr_out=0 at cycle 1; PREFETCH occupies cycles 1..READ_LATENCY+1; READY from cycle READ_LATENCY+2 (cycle 4 at defaults).
- Strobe sampled in READY at cycle s -> audio_out/audio_valid_out visible at cycle s+1; next address at s+1; READY again at s+READ_LATENCY+3.
- Minimum strobe spacing for underrun-free playback: READ_LATENCY+3 cycles (5 at defaults). Nominal spacing is thousands of cycles.
- done_out and final audio_valid_out in the same cycle; busy_out=0 from that cycle.
- All outputs registered; no combinational input-to-output paths.

## Test plan
- One-shot: RAM[0..3]={5,-3,127,-128}, length_in=4, loop_in=0, play, strobe every 20 cycles -> audio_out 5,-3,127,-128 with four valid pulses; done_out with the 4th; busy_out=0 after it; audio_out stays -128.
- Loop: same buffer, loop_in=1, 10 strobes -> 5,-3,127,-128,5,-3,127,-128,5,-3; done_out never pulses; ram_addr_out returns to 0 after address 3.
- Underrun: play, then strobe at cycle 2 (during PREFETCH) -> underrun_out pulse at cycle 3, no audio_valid_out; next strobe at cycle 10 -> audio_out=5.
- Stop and reset: stop_in coincident with a strobe at the 2nd sample -> no valid pulse, no done_out, IDLE next cycle. Separately, assert rst_in low mid-PREFETCH -> all outputs 0 immediately.
- Ignored requests: play_in with length_in=0 -> busy_out stays 0. play_in while busy with a new length_in=1 -> original 4-sample playback unchanged. play_in and stop_in in the same cycle -> stays IDLE.
- Latency: READ_LATENCY=2 -> READY at cycle 4 after play_in; strobe at cycle 4 -> audio_valid_out at cycle 5; strobes 5 cycles apart -> no underrun; 4 cycles apart -> underrun_out pulses.
